// File: rtl/bpc_decbuf_if.sv
// ---------------------------------------------------------------------------
// bpc_decbuf_if
// Bundles the code-word input handshake and the decoder-facing window and
// consume signals of the BPC decoder code buffer.
//   data_i/valid_i/sop_i/size_i : packed code words in, one block at a time
//   ready_o                     : word accepted when valid_i & ready_o
//   window_o/avail_o            : MSB-first view of the next unconsumed bits
//   cons_valid_i/cons_size_i    : decoder consumes cons_size_i bits this cycle
//   sop_o/eop_o                 : block start / block end pulses
// Modports: slave = buffer side, master = producer/decoder side.
// ---------------------------------------------------------------------------
interface bpc_decbuf_if #(
  parameter int DATA_W = 64,
  parameter int WIN_W  = 146
);
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              sop_i;
  logic [10:0]       size_i;
  logic              ready_o;
  logic [WIN_W-1:0]  window_o;
  logic [8:0]        avail_o;
  logic              cons_valid_i;
  logic [7:0]        cons_size_i;
  logic              sop_o;
  logic              eop_o;

  modport slave (
    input  data_i, valid_i, sop_i, size_i, cons_valid_i, cons_size_i,
    output ready_o, window_o, avail_o, sop_o, eop_o
  );

  modport master (
    output data_i, valid_i, sop_i, size_i, cons_valid_i, cons_size_i,
    input  ready_o, window_o, avail_o, sop_o, eop_o
  );
endinterface

// File: rtl/bpc_decbuf.sv
// ---------------------------------------------------------------------------
// bpc_decbuf
// Decoder-side code buffer for BPC. Accepts the 64-bit packed words of one
// compressed block (up to 8 words / 512 bits), keeps a bit-accurate FIFO and
// presents the next unconsumed bits MSB-first to the symbol decoder, which
// consumes a variable number of bits per cycle. Padding after the block's
// last bit is discarded and end of block is pulsed on eop_o.
//
// Ports
//   clk   : clock, all state updates on the rising edge
//   rst   : asynchronous active-high reset, discards any block in flight
//   bus   : bpc_decbuf_if.slave (word input, window/avail, consume, sop/eop)
//   err_o : sticky error flag, present only with BPC_DECBUF_ERR_EN
//
// Configuration macro: BPC_DECBUF_ERR_EN
//   defined     : err_o added; illegal consumes are ignored and flagged,
//                 non-sop words in IDLE and word exhaustion also flag.
//   not defined : illegal consumes are clamped to avail_o.
// ---------------------------------------------------------------------------
module bpc_decbuf #(
  parameter int DATA_W    = 64,
  parameter int WIN_W     = 146,
  parameter int BUF_W     = 256,
  parameter int MAX_WORDS = 8
) (
  input  logic         clk,
  input  logic         rst,
  bpc_decbuf_if.slave  bus
`ifdef BPC_DECBUF_ERR_EN
  ,
  output logic         err_o
`endif
);

  localparam int MAX_BITS = MAX_WORDS * DATA_W;
  localparam int BITS_W   = $clog2(BUF_W + 1);
  localparam int REM_W    = $clog2(MAX_BITS + 1);
  localparam int WL_W     = $clog2(MAX_WORDS) + 1;
  localparam int SIZE_W   = 11;
  localparam int LOG_DW   = $clog2(DATA_W);
  localparam int PAD_W    = REM_W - BITS_W;

  localparam logic [BITS_W-1:0] WIN_LIM  = BITS_W'(WIN_W);
  localparam logic [BITS_W-1:0] ROOM_LIM = BITS_W'(BUF_W - DATA_W);
  localparam logic [BITS_W-1:0] WORD_LEN = BITS_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [BITS_W-1:0]  bits_q, bits_d;
  logic [REM_W-1:0]   remain_q, remain_d;
  logic [WL_W-1:0]    words_left_q, words_left_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;

  logic [BITS_W-1:0]  avail;
  logic [WIN_W-1:0]   win_mask;
  logic               ready;
  logic               accept;
  logic               illegal;
  logic [BITS_W-1:0]  cons_amt;
  logic [REM_W-1:0]   size_clamped;
  logic [WL_W-1:0]    new_words_left;
  logic [BUF_W-1:0]   word_top;
  logic [BUF_W-1:0]   shifted;
  logic [BITS_W-1:0]  bits_post;
  logic               start_block;

`ifdef BPC_DECBUF_ERR_EN
  logic err_q, err_d;
  assign err_o = err_q;
`endif

  // Valid window length: limited by what is buffered, by the window width
  // and by the bits still belonging to the block (hides word padding).
  always_comb begin
    avail = bits_q;
    if (avail > WIN_LIM) avail = WIN_LIM;
    if ({{PAD_W{1'b0}}, avail} > remain_q) avail = remain_q[BITS_W-1:0];
  end

  // Bits past avail are forced to zero so the decoder never sees padding.
  assign win_mask     = ~({WIN_W{1'b1}} >> avail);
  assign bus.window_o = buf_q[BUF_W-1 -: WIN_W] & win_mask;
  assign bus.avail_o  = avail;
  assign bus.sop_o    = sop_q;
  assign bus.eop_o    = eop_q;

  // Ready comes only from registered state so it never depends on the
  // same-cycle consume; held low while reset is asserted.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      IDLE:    ready = 1'b1;
      RUN:     ready = (bits_q <= ROOM_LIM) && (words_left_q != '0);
      DRAIN:   ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign bus.ready_o = ready & ~rst;
  assign accept      = bus.valid_i & bus.ready_o;

  // Consume amount actually applied this cycle.
  assign illegal = bus.cons_valid_i && (BITS_W'(bus.cons_size_i) > avail);

  always_comb begin
    cons_amt = '0;
    if (bus.cons_valid_i) begin
`ifdef BPC_DECBUF_ERR_EN
      if (!illegal) cons_amt = BITS_W'(bus.cons_size_i);
`else
      cons_amt = illegal ? avail : BITS_W'(bus.cons_size_i);
`endif
    end
  end

  assign size_clamped   = (bus.size_i > SIZE_W'(MAX_BITS)) ? REM_W'(MAX_BITS)
                                                           : bus.size_i[REM_W-1:0];
  assign new_words_left = WL_W'((size_clamped - REM_W'(1)) >> LOG_DW);
  assign word_top       = {bus.data_i, {(BUF_W-DATA_W){1'b0}}};

  // Next-state logic. Block starts from IDLE or DRAIN share one path at the
  // end via start_block. In RUN the consume is applied first and an accepted
  // word is appended right after whatever survives that consume.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    bits_d       = bits_q;
    remain_d     = remain_q;
    words_left_d = words_left_q;
    sop_d        = 1'b0;
    eop_d        = 1'b0;
    start_block  = 1'b0;
    shifted      = buf_q << cons_amt;
    bits_post    = bits_q - cons_amt;
`ifdef BPC_DECBUF_ERR_EN
    err_d        = err_q | illegal;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.sop_i) begin
            start_block = 1'b1;
          end
`ifdef BPC_DECBUF_ERR_EN
          else begin
            err_d = 1'b1;
          end
`endif
        end
      end

      RUN: begin
        // sop_i is not looked at here; every accepted word is block data.
        buf_d    = shifted;
        bits_d   = bits_post;
        remain_d = remain_q - {{PAD_W{1'b0}}, cons_amt};
        if (accept) begin
          buf_d        = shifted | (word_top >> bits_post);
          bits_d       = bits_post + WORD_LEN;
          words_left_d = words_left_q - WL_W'(1);
        end
        if (remain_d == '0) begin
          eop_d   = 1'b1;
          buf_d   = '0;
          bits_d  = '0;
          state_d = (words_left_d == '0) ? IDLE : DRAIN;
        end else if ((words_left_d == '0) &&
                     ({{PAD_W{1'b0}}, bits_d} < remain_d)) begin
          // The block can never complete; close it so the decoder is not
          // left waiting on bits that will not arrive.
          eop_d   = 1'b1;
          buf_d   = '0;
          bits_d  = '0;
          state_d = IDLE;
`ifdef BPC_DECBUF_ERR_EN
          err_d   = 1'b1;
`endif
        end
      end

      DRAIN: begin
        if (accept) begin
          if (bus.sop_i) begin
            start_block = 1'b1;
          end else begin
            words_left_d = words_left_q - WL_W'(1);
            if (words_left_q == WL_W'(1)) state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (start_block) begin
      if (size_clamped == '0) begin
        eop_d        = 1'b1;
        words_left_d = '0;
        buf_d        = '0;
        bits_d       = '0;
        state_d      = IDLE;
      end else begin
        buf_d        = word_top;
        bits_d       = WORD_LEN;
        remain_d     = size_clamped;
        words_left_d = new_words_left;
        sop_d        = 1'b1;
        state_d      = RUN;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      bits_q       <= '0;
      remain_q     <= '0;
      words_left_q <= '0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      bits_q       <= bits_d;
      remain_q     <= remain_d;
      words_left_q <= words_left_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
    end
  end

`ifdef BPC_DECBUF_ERR_EN
  // Sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`endif

endmodule

// File: tb/tb_bpc_decbuf.sv
// ---------------------------------------------------------------------------
// tb_bpc_decbuf
// Self-checking bench for bpc_decbuf. A reference model keeps the buffered
// block as a queue of bits and derives ready/avail/window/sop/eop (and err
// with BPC_DECBUF_ERR_EN) every cycle; directed scenarios are followed by
// randomized blocks and a free-running random phase.
// ---------------------------------------------------------------------------
module tb_bpc_decbuf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bpc_decbuf_if bus ();

`ifdef BPC_DECBUF_ERR_EN
  logic err_o;
  bpc_decbuf dut (.clk(clk), .rst(rst), .bus(bus), .err_o(err_o));
`else
  bpc_decbuf dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: the block's buffered bits in stream order.
  bit mq[$];
  int mRemain;
  int mWl;
  int mMode;   // 0 idle, 1 receiving/decoding a block, 2 discarding words
  bit mSop;
  bit mEop;
  bit mErr;

  task automatic checkOutput(input string tag, input logic [255:0] obs,
                             input logic [255:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int modelAvail();
    int a;
    a = mq.size();
    if (a > 146) a = 146;
    if (a > mRemain) a = mRemain;
    return a;
  endfunction

  function automatic bit modelReady();
    if (mMode == 1) return (mq.size() <= 192) && (mWl != 0);
    return 1'b1;
  endfunction

  function automatic logic [145:0] modelWindow();
    logic [145:0] w;
    int a;
    w = '0;
    a = modelAvail();
    for (int i = 0; i < a; i++) w[145-i] = mq[i];
    return w;
  endfunction

  task automatic modelReset();
    mq.delete();
    mRemain = 0;
    mWl     = 0;
    mMode   = 0;
    mSop    = 0;
    mEop    = 0;
    mErr    = 0;
  endtask

  task automatic modelLoad(input logic [63:0] d, input int size);
    int sz;
    sz = (size > 512) ? 512 : size;
    if (sz == 0) begin
      mEop = 1;
      mWl  = 0;
      mq.delete();
      mMode = 0;
    end else begin
      mq.delete();
      for (int i = 63; i >= 0; i--) mq.push_back(d[i]);
      mRemain = sz;
      mWl     = (sz + 63) / 64 - 1;
      mMode   = 1;
      mSop    = 1;
    end
  endtask

  task automatic modelStep(input logic v, input logic s, input logic [63:0] d,
                           input int sz, input logic cv, input int cs);
    int av;
    int c;
    bit acc;
    bit illegal;
    av      = modelAvail();
    acc     = v && modelReady();
    illegal = cv && (cs > av);
    mSop    = 0;
    mEop    = 0;
`ifdef BPC_DECBUF_ERR_EN
    if (illegal) mErr = 1;
`endif
    case (mMode)
      0: begin
        if (acc) begin
          if (s) modelLoad(d, sz);
`ifdef BPC_DECBUF_ERR_EN
          else mErr = 1;
`endif
        end
      end
      1: begin
        c = 0;
        if (cv) begin
`ifdef BPC_DECBUF_ERR_EN
          c = illegal ? 0 : cs;
`else
          c = illegal ? av : cs;
`endif
        end
        for (int i = 0; i < c; i++) void'(mq.pop_front());
        mRemain -= c;
        if (acc) begin
          for (int i = 63; i >= 0; i--) mq.push_back(d[i]);
          mWl--;
        end
        if (mRemain == 0) begin
          mEop = 1;
          mq.delete();
          mMode = (mWl == 0) ? 0 : 2;
        end else if (mWl == 0 && mq.size() < mRemain) begin
          mEop = 1;
          mq.delete();
          mMode = 0;
`ifdef BPC_DECBUF_ERR_EN
          mErr = 1;
`endif
        end
      end
      default: begin
        if (acc) begin
          if (s) modelLoad(d, sz);
          else begin
            mWl--;
            if (mWl == 0) mMode = 0;
          end
        end
      end
    endcase
  endtask

  task automatic checkAll();
    checkOutput("ready", bus.ready_o, modelReady());
    checkOutput("avail", bus.avail_o, modelAvail());
    checkOutput("window", bus.window_o, modelWindow());
    checkOutput("sop", bus.sop_o, mSop);
    checkOutput("eop", bus.eop_o, mEop);
`ifdef BPC_DECBUF_ERR_EN
    checkOutput("err", err_o, mErr);
`endif
  endtask

  // Drive one cycle of inputs (called at the falling edge), advance the
  // model on the rising edge and compare on the next falling edge.
  task automatic applyStimulus(input logic v, input logic s, input logic [63:0] d,
                               input int sz, input logic cv, input int cs);
    bus.valid_i      = v;
    bus.sop_i        = s;
    bus.data_i       = d;
    bus.size_i       = 11'(sz);
    bus.cons_valid_i = cv;
    bus.cons_size_i  = 8'(cs);
    @(posedge clk);
    modelStep(v, s, d, sz, cv, cs);
    @(negedge clk);
    checkAll();
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic finishBlock(input int step, input int validPct, input int consPct,
                             input int maxCycles);
    int cyc;
    int av;
    int cs;
    logic v;
    logic cv;
    cyc = 0;
    while (mMode != 0 && cyc < maxCycles) begin
      av = modelAvail();
      cv = (av > 0) && ($urandom_range(0, 99) < consPct);
      if (av == 0)       cs = 1;
      else if (step > 0) cs = (step < av) ? step : av;
      else               cs = $urandom_range(1, av);
      v = (mWl > 0) && ($urandom_range(0, 99) < validPct);
      applyStimulus(v, 1'b0, rand64(), 0, cv, cs);
      cyc++;
    end
    checkOutput("block_within_budget", cyc < maxCycles, 1'b1);
  endtask

  function automatic int randSize();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r == 1) return $urandom_range(513, 2047);
    if (r == 2) return 64 * $urandom_range(1, 8);
    return $urandom_range(1, 512);
  endfunction

  initial begin
    #950000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] w;
    logic [63:0] w2;
    logic [145:0] winSave;
    int av;
    int cs;
    logic s;
    logic cv;

    modelReset();
    rst              = 1'b1;
    bus.valid_i      = 1'b0;
    bus.sop_i        = 1'b0;
    bus.data_i       = '0;
    bus.size_i       = '0;
    bus.cons_valid_i = 1'b0;
    bus.cons_size_i  = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", bus.ready_o, 1'b0);
    checkOutput("rst_window", bus.window_o, '0);
    checkOutput("rst_avail", bus.avail_o, '0);
    rst = 1'b0;
    #1;
    checkAll();
    @(negedge clk);

    // Single-word block.
    applyStimulus(1, 1, 64'hDEADBEEF01234567, 64, 0, 0);
    checkOutput("t1_avail", bus.avail_o, 64);
    checkOutput("t1_word", bus.window_o[145:82], 64'hDEADBEEF01234567);
    checkOutput("t1_sop", bus.sop_o, 1'b1);
    applyStimulus(0, 0, '0, 0, 1, 64);
    checkOutput("t1_eop", bus.eop_o, 1'b1);
    checkOutput("t1_avail_end", bus.avail_o, 0);

    // 200-bit block consumed 13 bits at a time.
    applyStimulus(1, 1, rand64(), 200, 0, 0);
    finishBlock(13, 100, 100, 400);

    // Accept and consume in the same cycle.
    applyStimulus(1, 1, rand64(), 512, 0, 0);
    applyStimulus(1, 0, rand64(), 0, 0, 0);
    applyStimulus(1, 0, rand64(), 0, 1, 42);
    w = rand64();
    applyStimulus(1, 0, w, 0, 1, 40);
    checkOutput("t3_avail", bus.avail_o, 146);
    checkOutput("t3_newword", bus.window_o[35:0], w[63:28]);
    finishBlock(0, 80, 70, 600);

    // Reset in the middle of a block.
    applyStimulus(1, 1, rand64(), 512, 0, 0);
    applyStimulus(1, 0, rand64(), 0, 1, 8);
    checkOutput("t5_avail_pre", bus.avail_o, 120);
    rst = 1'b1;
    #1;
    checkOutput("t5_window", bus.window_o, '0);
    checkOutput("t5_avail", bus.avail_o, '0);
    checkOutput("t5_ready", bus.ready_o, 1'b0);
    checkOutput("t5_eop", bus.eop_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    #1;
    checkAll();
    @(negedge clk);
    applyStimulus(1, 1, rand64(), 150, 0, 0);
    finishBlock(0, 90, 80, 600);

    // Consume larger than avail.
    applyStimulus(1, 1, rand64(), 74, 0, 0);
    applyStimulus(0, 0, '0, 0, 1, 54);
    checkOutput("t6_avail10", bus.avail_o, 10);
    winSave = bus.window_o;
    applyStimulus(0, 0, '0, 0, 1, 20);
`ifdef BPC_DECBUF_ERR_EN
    checkOutput("t6_err", err_o, 1'b1);
    checkOutput("t6_avail_kept", bus.avail_o, 10);
    checkOutput("t6_window_kept", bus.window_o, winSave);
`else
    checkOutput("t6_avail_clamped", bus.avail_o, 0);
    w2 = rand64();
    applyStimulus(1, 0, w2, 0, 0, 0);
    checkOutput("t6_avail_w2", bus.avail_o, 10);
    checkOutput("t6_window_w2", bus.window_o[145:136], w2[63:54]);
`endif
    finishBlock(0, 90, 90, 600);

    // Randomized whole blocks.
    for (int b = 0; b < 40; b++) begin
      applyStimulus(1, 1, rand64(), randSize(), 0, 0);
      finishBlock(0, $urandom_range(30, 100), $urandom_range(30, 100), 1500);
    end

    // Free-running random inputs, with one asynchronous reset.
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        rst = 1'b1;
        #1;
        checkOutput("rand_rst_avail", bus.avail_o, '0);
        checkOutput("rand_rst_ready", bus.ready_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        #1;
        checkAll();
        @(negedge clk);
      end
      av = modelAvail();
      cv = 1'b0;
      cs = 1;
      if (av > 0) begin
        cv = $urandom_range(0, 1);
        if ($urandom_range(0, 7) == 0 && av < 146) cs = $urandom_range(av + 1, 146);
        else cs = $urandom_range(1, av);
      end
      if (mMode == 0) s = ($urandom_range(0, 7) != 0);
      else            s = ($urandom_range(0, 7) == 0);
      applyStimulus($urandom_range(0, 3) != 0, s, rand64(), randSize(), cv, cs);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
